mac_inverse_div_8_bit: RTL and testbench

//  Sequential inverse of the 8-bit Dadda multiply-accumulate (p = a*b + acc).

---
 rtl/mac_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/mac_inverse_div_8_bit.sv | 125 ++++++++++++
 tb/tb_mac_inverse_div_8_bit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC inverse divider.
package mac_pkg;

  localparam int MAC_A_W   = 8;
  localparam int MAC_ACC_W = 16;
  localparam int MAC_P_W   = 2 * MAC_A_W + 1;
  localparam int MAC_CNT_W = $clog2(MAC_P_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract b.
module div_step #(
  parameter int A_W = 8
) (
  input  logic [A_W:0]   r_i,
  input  logic           bit_i,
  input  logic [A_W-1:0] b_i,
  output logic [A_W:0]   r_o,
  output logic           q_o
);

  logic [A_W+1:0] r_sh;
  logic [A_W+1:0] b_ext;

  // Shift the remainder left by one, compare against b and restore on borrow.
  always_comb begin
    r_sh  = {r_i, bit_i};
    b_ext = {2'b00, b_i};
    q_o   = (r_sh >= b_ext);
    r_o   = (A_W+1)'(q_o ? (r_sh - b_ext) : r_sh);
  end

endmodule

// File: rtl/mac_inverse_div_8_bit.sv
// Recovers a = (p - acc) / b from a MAC result, one quotient bit per clock.
module mac_inverse_div_8_bit
  import mac_pkg::*;
#(
  parameter int A_W   = MAC_A_W,
  parameter int ACC_W = MAC_ACC_W,
  parameter int P_W   = MAC_P_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [P_W-1:0]   p,
  input  logic [ACC_W-1:0] acc,
  input  logic [A_W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [A_W-1:0]   a,
  output logic [A_W-1:0]   rem,
  output logic             dz,
  output logic             neg,
  output logic             ovf
);

  localparam int CNT_W = $clog2(P_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P_W - 1);

  state_e           state_q;
  logic [P_W-1:0]   p_q;
  logic [ACC_W-1:0] acc_q;
  logic [A_W-1:0]   b_q;
  logic [P_W-1:0]   dvd_q;
  logic [P_W-2:0]   q_q;
  logic [A_W:0]     r_q;
  logic [CNT_W-1:0] cnt_q;

  logic [P_W:0]     diff_d;
  logic [A_W:0]     r_d;
  logic             qbit_d;
  logic [P_W-1:0]   q_d;

  // Difference is one bit wider than p so its MSB is the borrow (p < acc).
  assign diff_d = {1'b0, p_q} - (P_W+1)'(acc_q);
  assign q_d    = {q_q, qbit_d};

  div_step #(.A_W(A_W)) u_step (
    .r_i   (r_q),
    .bit_i (dvd_q[P_W-1]),
    .b_i   (b_q),
    .r_o   (r_d),
    .q_o   (qbit_d)
  );

  // Control FSM with operand latching, iteration and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a       <= '0;
      rem     <= '0;
      dz      <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            p_q     <= p;
            acc_q   <= acc;
            b_q     <= b;
            busy    <= 1'b1;
            dz      <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            state_q <= PREP;
          end
        end
        PREP: begin
          if (b_q == '0) begin
            dz      <= 1'b1;
            a       <= '1;
            rem     <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (diff_d[P_W]) begin
            neg     <= 1'b1;
            a       <= '0;
            rem     <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            dvd_q   <= diff_d[P_W-1:0];
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          dvd_q <= {dvd_q[P_W-2:0], 1'b0};
          r_q   <= r_d;
          q_q   <= q_d[P_W-2:0];
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
            rem     <= r_d[A_W-1:0];
            if (|q_d[P_W-1:A_W]) begin
              ovf <= 1'b1;
              a   <= '1;
            end else begin
              a   <= q_d[A_W-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_inverse_div_8_bit.sv
// Directed bench for the MAC inverse divider.
module tb_mac_inverse_div_8_bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [16:0] p;
  logic [15:0] acc;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  a;
  logic [7:0]  rem;
  logic        dz;
  logic        neg;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  mac_inverse_div_8_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .acc   (acc),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .a     (a),
    .rem   (rem),
    .dz    (dz),
    .neg   (neg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, scramble inputs while busy, and check the result at done.
  task automatic run_op(input string tag, input logic [16:0] pv, input logic [15:0] av,
                        input logic [7:0] bv, input int lat, input logic [7:0] ea,
                        input logic [7:0] er, input logic edz, input logic eneg,
                        input logic eovf, input int glitch, output int done_edge);
    int got;
    int busy_drop;
    got = 99;
    busy_drop = 0;
    done_edge = -1;
    p = pv; acc = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    p = 17'($urandom); acc = 16'($urandom); b = 8'($urandom);
    chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      start = (k == glitch);
      tick();
      if (done) begin
        got = k;
        done_edge = edge_n;
        break;
      end
      if (busy !== 1'b1) busy_drop++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(got), 32'(lat));
    chk({tag, ".busy_held"}, 32'(busy_drop), 32'd0);
    chk({tag, ".a"}, 32'(a), 32'(ea));
    chk({tag, ".rem"}, 32'(rem), 32'(er));
    chk({tag, ".flags"}, 32'({dz, neg, ovf}), 32'({edz, eneg, eovf}));
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int de1, de2, t0, seen;
    logic [7:0] ra, rb;
    logic [15:0] rc;
    rst_n = 1'b0; start = 1'b0; p = '0; acc = '0; b = '0;
    repeat (3) tick();
    chk("reset.outs", 32'({busy, done, a, rem, dz, neg, ovf}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. 65025 / 255
    run_op("t1", 17'h10D10, 16'h0F0F, 8'hFF, 18, 8'hFF, 8'h00, 0, 0, 0, 0, de1);
    tick();
    chk("t1.done_pulse", 32'(done), 32'd0);
    chk("t1.a_hold", 32'(a), 32'hFF);

    // 2. 65030 / 255 = 255 r 5
    run_op("t2", 17'h10D15, 16'h0F0F, 8'hFF, 18, 8'hFF, 8'h05, 0, 0, 0, 0, de1);
    // 3. divide by zero beats p < acc
    run_op("t3", 17'h00010, 16'h1000, 8'h00, 1, 8'hFF, 8'h00, 1, 0, 0, 0, de1);
    // 4. negative difference
    run_op("t4", 17'h00100, 16'h0200, 8'h03, 1, 8'h00, 8'h00, 0, 1, 0, 0, de1);
    // 5. overflow
    run_op("t5", 17'h1FFFF, 16'h0000, 8'h01, 18, 8'hFF, 8'h00, 0, 0, 1, 0, de1);
    // 93 / 10 = 9 r 3
    run_op("t_9r3", 17'h00064, 16'h0007, 8'h0A, 18, 8'h09, 8'h03, 0, 0, 0, 0, de1);
    // p == acc gives zero quotient, not negative
    run_op("t_zero", 17'h01234, 16'h1234, 8'h05, 18, 8'h00, 8'h00, 0, 0, 0, 0, de1);
    // 255 / 1 just fits, 256 / 1 overflows
    run_op("t_255", 17'h000FF, 16'h0000, 8'h01, 18, 8'hFF, 8'h00, 0, 0, 0, 0, de1);
    run_op("t_256", 17'h00100, 16'h0000, 8'h01, 18, 8'hFF, 8'h00, 0, 0, 1, 0, de1);

    // 6b. start pulsed at E5 while busy is ignored
    run_op("t6b", 17'h10D15, 16'h0F0F, 8'hFF, 18, 8'hFF, 8'h05, 0, 0, 0, 5, de1);

    // 6c. back-to-back: second start at E19, second done at E37
    tick();
    t0 = edge_n + 1;
    run_op("t6c.first", 17'h00064, 16'h0007, 8'h0A, 18, 8'h09, 8'h03, 0, 0, 0, 0, de1);
    run_op("t6c.second", 17'h10D15, 16'h0F0F, 8'hFF, 18, 8'hFF, 8'h05, 0, 0, 0, 0, de2);
    chk("t6c.e37", 32'(de2 - t0), 32'd37);

    // 6a. reset at E10 aborts the divide
    p = 17'h10D10; acc = 16'h0F0F; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6a.outs", 32'({busy, done, a, rem, dz, neg, ovf}), 32'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("t6a.no_done", 32'(seen), 32'd0);

    // Random MAC round trips: p = a*b + acc must decode back to a with zero remainder
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255, 1));
      rc = 16'($urandom);
      run_op($sformatf("rnd%0d", i), 17'(int'(ra) * int'(rb) + int'(rc)), rc, rb, 18,
             ra, 8'h00, 0, 0, 0, 0, de1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
